// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and the
// data stage: IDLE -> ISSUE -> WAIT -> DONE per transaction, with bounded fetch starvation.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state_o,
  output logic [3:0]    dbg_streak_o
);

  // Handshakes: if_req/dm_req are levels held until the matching one-cycle ack and are
  // sampled only in IDLE; mem_req is held until mem_ready is seen in ISSUE or WAIT.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  state_t        state_q;
  logic [3:0]    streak_q, streak_d;
  logic [9:0]    timer_q;
  logic          gnt_q, gnt_d;
  logic          tmo_hit, done_d;
  logic          if_ack_q, dm_ack_q, bus_err_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

  always_comb begin
    // Data wins ties (older instruction) until fetch has waited out STARVE_LIMIT grants.
    gnt_d    = dm_req & ~(if_req & (streak_q == STREAK_MAX));
    streak_d = '0;
    if (gnt_d && if_req)
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
    tmo_hit = (state_q == S_WAIT) && !mem_ready && (timer_q == TMO_LAST);
    done_d  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (mem_ready || tmo_hit);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      timer_q     <= '0;
      gnt_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_req || dm_req) begin
            state_q     <= S_ISSUE;
            gnt_q       <= gnt_d;
            streak_q    <= streak_d;
            timer_q     <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= gnt_d & dm_we;
            mem_addr_q  <= gnt_d ? dm_addr : if_addr;
            mem_wdata_q <= gnt_d ? dm_wdata : '0;
          end
        end
        S_ISSUE, S_WAIT: begin
          // Timer only runs in WAIT; on expiry it lands exactly on TIMEOUT.
          if (state_q == S_WAIT && !mem_ready)
            timer_q <= timer_q + 10'd1;
          if (done_d) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            if_ack_q  <= ~gnt_q;
            dm_ack_q  <= gnt_q;
            bus_err_q <= tmo_hit;
            if (!gnt_q)
              if_rdata_q <= tmo_hit ? '0 : mem_rdata;
            else if (!mem_we_q)
              dm_rdata_q <= tmo_hit ? '0 : mem_rdata;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          if_ack_q  <= 1'b0;
          dm_ack_q  <= 1'b0;
          bus_err_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_ack       = if_ack_q;
  assign dm_ack       = dm_ack_q;
  assign bus_err      = bus_err_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign dbg_state_o  = state_q;
  assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for reset/idle corners,
// then randomized requester traffic against a transaction-level grant/data model.
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk, reset_b;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ack, dm_ack, bus_err, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_streak;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_b(reset_b),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state), .dbg_streak_o(dbg_streak)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];          // {gnt, err, rdata of granted port}
  logic [31:0] last_if = '0;      // expected held if_rdata
  logic [31:0] last_dm = '0;      // expected held dm_rdata

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        ifr, dmr, we;
    logic [31:0] ia, da, wd, rd;
    int          dly;        // mem_ready this many cycles after mem_req rises; -1 = never
    logic        exp_gnt;    // 0 = fetch, 1 = data
    logic        exp_err;
    logic [31:0] exp_addr;
    int          exp_cyc;    // cycle of the ack, counting the sampling IDLE cycle as 0
  } vec_t;

  function automatic vec_t mk(input logic ifr, dmr, we, input logic [31:0] ia, da, wd, rd,
                              input int dly, input logic eg, ee, input logic [31:0] ea,
                              input int ec);
    vec_t v;
    v.ifr = ifr; v.dmr = dmr; v.we = we; v.ia = ia; v.da = da; v.wd = wd; v.rd = rd;
    v.dly = dly; v.exp_gnt = eg; v.exp_err = ee; v.exp_addr = ea; v.exp_cyc = ec;
    return v;
  endfunction

  // ---------------- driver: one full transaction from an IDLE-cycle negedge ----------------
  task automatic run_txn(input vec_t v, input string tag);
    logic [33:0] e, g;
    logic [31:0] exp_rd;
    int          ack_cyc;
    logic        held;
    chk({tag, "_idle_quiet"}, 64'({if_ack, dm_ack, bus_err, mem_req}), 64'(0));
    if_req = v.ifr; if_addr = v.ia;
    dm_req = v.dmr; dm_we = v.we; dm_addr = v.da; dm_wdata = v.wd;
    mem_ready = 1'($urandom_range(0, 1));   // ignored while IDLE
    mem_rdata = $urandom;
    if (v.exp_gnt && v.we) exp_rd = last_dm;
    else                   exp_rd = v.exp_err ? 32'h0 : v.rd;
    exp_q.push_back({v.exp_gnt, v.exp_err, exp_rd});
    ack_cyc = 0;
    held    = 1'b1;
    for (int c = 1; c <= TO + 8; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        ack_cyc = c;
        break;
      end
      if (c == 1) begin
        chk({tag, "_issue_addr"}, 64'(mem_addr), 64'(v.exp_addr));
        chk({tag, "_issue_we"}, 64'(mem_we), 64'(v.exp_gnt & v.we));
        if (v.exp_gnt && v.we) chk({tag, "_issue_wdata"}, 64'(mem_wdata), 64'(v.wd));
        if (!v.exp_gnt) chk({tag, "_streak_cleared"}, 64'(dbg_streak), 64'(0));
        // inputs of the granted port change mid-transaction and must not leak through
        if (v.exp_gnt) begin
          dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(0, 1));
        end else begin
          if_addr = $urandom;
        end
      end
      if (!mem_req || bus_err) held = 1'b0;
      mem_ready = (v.dly >= 0) && (c - 1 == v.dly);
      mem_rdata = mem_ready ? v.rd : $urandom;
    end
    chk({tag, "_mem_req_held"}, 64'(held), 64'(1));
    chk({tag, "_ack_cycle"}, 64'(ack_cyc), 64'(v.exp_cyc));
    e = exp_q.pop_front();
    if (ack_cyc != 0) begin
      g = {dm_ack, bus_err, dm_ack ? dm_rdata : if_rdata};
      chk({tag, "_ack_data"}, 64'(g), 64'(e));
      chk({tag, "_ack_ports"}, 64'({if_ack, dm_ack}), 64'({~v.exp_gnt, v.exp_gnt}));
      chk({tag, "_mem_req_dropped"}, 64'(mem_req), 64'(0));
      if (v.exp_gnt) chk({tag, "_if_rdata_held"}, 64'(if_rdata), 64'(last_if));
      else           chk({tag, "_dm_rdata_held"}, 64'(dm_rdata), 64'(last_dm));
    end
    if (!v.exp_gnt)     last_if = exp_rd;
    else if (!v.we)     last_dm = exp_rd;
    mem_ready = 1'($urandom_range(0, 1));     // ignored in DONE
    mem_rdata = $urandom;
    if (v.exp_gnt) dm_req = 1'b0;
    else           if_req = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  vec_t        tbl[15];
  logic [9:0]  sim_gnt;
  logic        if_p, dm_p, p_we, gnt;
  logic [31:0] p_ia, p_da, p_wd;
  int          streak_m, dly;
  vec_t        rv;

  initial begin
    reset_b = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    tbl[0] = mk(1, 0, 0, 32'h00400000, 0, 0, 32'h20080005, 1, 0, 0, 32'h00400000, 3);
    tbl[1] = mk(0, 1, 1, 0, 32'h10, 32'hDEADBEEF, 32'h55555555, 3, 1, 0, 32'h10, 5);
    tbl[2] = mk(0, 1, 0, 0, 32'h20, 0, 32'h12345678, 0, 1, 0, 32'h20, 2);
    tbl[3] = mk(0, 1, 0, 0, 32'h44, 0, 32'h99999999, -1, 1, 1, 32'h44, TO + 2);
    tbl[4] = mk(1, 0, 0, 32'h00400004, 0, 0, 32'hCAFEF00D, 2, 0, 0, 32'h00400004, 4);
    sim_gnt = 10'b0111101111;   // D,D,D,D,I,D,D,D,D,I from LSB
    for (int k = 0; k < 10; k++) begin
      tbl[5 + k] = mk(1, 1, 1'(k % 2), 32'h1000 + 32'(4 * k), 32'h2000 + 32'(4 * k),
                      32'hB0000000 + 32'(k), 32'hA0000000 + 32'(k), 1, sim_gnt[k], 0,
                      sim_gnt[k] ? 32'h2000 + 32'(4 * k) : 32'h1000 + 32'(4 * k), 3);
    end

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({mem_req, mem_we, if_ack, dm_ack, bus_err}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdata", 64'({if_rdata, dm_rdata}), 64'(0));
    chk("rst_streak", 64'(dbg_streak), 64'(0));
    reset_b = 1'b1;

    // spurious mem_ready while idle
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk("idle_spurious_ready", 64'({if_ack, dm_ack, bus_err, mem_req}), 64'(0));
    chk("idle_spurious_rdata", 64'({if_rdata, dm_rdata}), 64'(0));
    mem_ready = 1'b0;

    for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // reset while in WAIT
    if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h80; mem_ready = 0;
    repeat (3) @(negedge clk);
    chk("rstmid_pre_mem_req", 64'(mem_req), 64'(1));
    #1 reset_b = 1'b0;
    #1 chk("rstmid_async_drop", 64'({mem_req, dm_ack, bus_err}), 64'(0));
    dm_req = 1'b0;
    @(negedge clk);
    chk("rstmid_cleared", 64'({if_rdata, dm_rdata}), 64'(0));
    reset_b = 1'b1;
    last_if = '0; last_dm = '0;
    exp_q.delete();
    run_txn(mk(1, 0, 0, 32'h00400008, 0, 0, 32'h13572468, 1, 0, 0, 32'h00400008, 3), "post_rst");

    // randomized traffic against the grant/data model
    if_p = 0; dm_p = 0; streak_m = 0;
    p_ia = '0; p_da = '0; p_wd = '0; p_we = 0;
    for (int n = 0; n < 150; n++) begin
      if (!if_p && $urandom_range(0, 9) < 7) begin
        if_p = 1; p_ia = $urandom & 32'hFFFFFFFC;
      end
      if (!dm_p && $urandom_range(0, 9) < 7) begin
        dm_p = 1; p_da = $urandom & 32'hFFFFFFFC; p_wd = $urandom; p_we = 1'($urandom_range(0, 1));
      end
      if (!if_p && !dm_p) begin
        if_req = 0; dm_req = 0; mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rand_idle", 64'({if_ack, dm_ack, bus_err, mem_req}), 64'(0));
        continue;
      end
      gnt = dm_p && !(if_p && streak_m >= SL);
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      rv = mk(if_p, dm_p, p_we, p_ia, p_da, p_wd, $urandom, dly, gnt, dly < 0,
              gnt ? p_da : p_ia, (dly < 0) ? TO + 2 : dly + 2);
      run_txn(rv, $sformatf("rnd%0d", n));
      if (gnt && if_p) streak_m = (streak_m < SL) ? streak_m + 1 : SL;
      else             streak_m = 0;
      if (gnt) dm_p = 0;
      else     if_p = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
